// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 16;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: one radix-2 step per cycle on a shared acc/op_b datapath,
// result written back to the register file through wb_*.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | WIDTH shift-add / restoring-divide steps
//   DONE  | one-cycle result pulse; may accept the next op
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH     = MDU_WIDTH,
  parameter int REGADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [REGADDR_W-1:0] dest,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic                 wb_en,
  output logic [REGADDR_W-1:0] wb_reg,
  output logic [WIDTH-1:0]     wb_data
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e state_q, state_d;

  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     op_b_q;
  logic [1:0]           op_q;
  logic [REGADDR_W-1:0] dest_q;
  logic [CNT_W-1:0]     count_q;
  logic [WIDTH-1:0]     wb_data_q;
  logic [REGADDR_W-1:0] wb_reg_q;
  logic                 dbz_q;

  logic                 accept;
  logic                 last_step;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic                 rem_fits;
  logic [WIDTH-1:0]     rem_diff;
  logic [2*WIDTH-1:0]   step_acc;

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last_step = (state_q == RUN) && (count_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Multiply: upper half accumulates, lower half shifts the multiplier out.
  // Divide: upper half is the partial remainder, lower half shifts the dividend out and quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_b_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_fits = (rem_sh >= {1'b0, op_b_q});
    rem_diff = rem_sh[WIDTH-1:0] - op_b_q;
    if (op_q[1])
      step_acc = {(rem_fits ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_fits};
    else
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      op_b_q    <= '0;
      op_q      <= OP_MUL;
      dest_q    <= '0;
      count_q   <= '0;
      wb_data_q <= '0;
      wb_reg_q  <= '0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      acc_q   <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
      op_b_q  <= op[1] ? b : a;
      op_q    <= op;
      dest_q  <= dest;
      count_q <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= step_acc;
      count_q <= count_q + 1'b1;
      if (last_step) begin
        // MULH and REMU both live in the upper half, MUL and DIVU in the lower half.
        wb_data_q <= op_q[0] ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
        wb_reg_q  <= dest_q;
        dbz_q     <= op_q[1] && (op_b_q == '0);
      end
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign wb_en       = done && (wb_reg_q != '0);
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic [2:0]  dest;
  logic        busy, done, div_by_zero, wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(16), .REGADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .dest(dest),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_res(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = {16'h0, x} * {16'h0, y};
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (y == 16'h0) ? 16'hFFFF : x / y;
      default: return (y == 16'h0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a posedge; accepts on the next edge, then counts edges until done.
  task automatic issue_and_wait(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                input logic [2:0] d, output int lat);
    op = o; a = x; b = y; dest = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); dest = 3'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [1:0] o, input logic [15:0] x,
                              input logic [15:0] y, input logic [2:0] d, input int lat);
    logic [15:0] r;
    r = ref_res(o, x, y);
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_data"}, 32'(wb_data), 32'(r));
    check({tag, "_reg"}, 32'(wb_reg), 32'(d));
    check({tag, "_wben"}, 32'(wb_en), 32'(d != 3'd0));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(o[1] && y == 16'h0));
  endtask

  task automatic check_after(input string tag, input logic [15:0] r);
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_wben_drop"}, 32'(wb_en), 32'd0);
    check({tag, "_data_hold"}, 32'(wb_data), 32'(r));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [2:0] d);
    int lat;
    issue_and_wait(o, x, y, d, lat);
    check_result(tag, o, x, y, d, lat);
    check_after(tag, ref_res(o, x, y));
  endtask

  initial begin
    int lat;
    int saw;
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    logic [2:0]  rd;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; dest = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_wben", 32'(wb_en), 32'd0);
    check("rst_reg", 32'(wb_reg), 32'd0);
    check("rst_data", 32'(wb_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul300x200", 2'b00, 16'd300, 16'd200, 3'd3);
    run_op("mulh_ffff", 2'b01, 16'hFFFF, 16'hFFFF, 3'd1);
    run_op("mul_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 3'd2);
    run_op("divu1000_7", 2'b10, 16'd1000, 16'd7, 3'd4);
    run_op("remu1000_7", 2'b11, 16'd1000, 16'd7, 3'd5);
    run_op("divu_by0", 2'b10, 16'd1234, 16'd0, 3'd6);
    run_op("remu_by0", 2'b11, 16'd1234, 16'd0, 3'd7);
    run_op("dest0", 2'b00, 16'd5, 16'd9, 3'd0);

    // Start pulsed mid-run is ignored.
    op = 2'b00; a = 16'd123; b = 16'd45; dest = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    op = 2'b10; a = 16'd999; b = 16'd3; dest = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    check_result("ignore_start", 2'b00, 16'd123, 16'd45, 3'd2, lat);
    check_after("ignore_start", ref_res(2'b00, 16'd123, 16'd45));

    // Back-to-back: start held in DONE.
    issue_and_wait(2'b01, 16'hABCD, 16'h1234, 3'd3, lat);
    check_result("b2b_first", 2'b01, 16'hABCD, 16'h1234, 3'd3, lat);
    op = 2'b11; a = 16'd50000; b = 16'd777; dest = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_single", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    check_result("b2b_second", 2'b11, 16'd50000, 16'd777, 3'd5, lat);
    check_after("b2b_second", ref_res(2'b11, 16'd50000, 16'd777));

    // Reset mid-run discards the operation.
    op = 2'b00; a = 16'd77; b = 16'd88; dest = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    check("midrst_wben", 32'(wb_en), 32'd0);
    check("midrst_reg", 32'(wb_reg), 32'd0);
    check("midrst_data", 32'(wb_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || wb_en || busy) saw++;
    end
    check("midrst_no_activity", 32'(saw), 32'd0);

    // Randomized ops, with a share of divide-by-zero.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = 16'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 1) == 0) rb = rb & 16'h00FF;
      rd = 3'($urandom);
      run_op($sformatf("rand%0d", i), ro, ra, rb, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
